// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM states, PPROT bit constants, default timeout.
package apb_pkg;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2,
    APB_RESP   = 2'd3
  } apb_state_t;

  localparam logic [2:0] PPROT_PRIV  = 3'b001;
  localparam logic [2:0] PPROT_NSEC  = 3'b010;
  localparam logic [2:0] PPROT_INSTR = 3'b100;

  localparam int unsigned APB_TIMEOUT_DEF = 255;

endpackage

// File: rtl/apb_initiator.sv
// APB4 requester: one valid/ready request in flight, converted to an
// APB SETUP/ACCESS transfer with a bounded wait-state timeout.
module apb_initiator
  import apb_pkg::*;
#(
  parameter int unsigned TIMEOUT = APB_TIMEOUT_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_write,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  input  logic [2:0]  req_prot,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] out_paddr,
  output logic [31:0] out_pwdata,
  output logic        out_psel,
  output logic        out_penable,
  output logic        out_pwrite,
  output logic [2:0]  out_pprot,
  output logic [3:0]  out_pstrb,
  input  logic        out_pready,
  input  logic        out_pslverr,
  input  logic [31:0] out_prdata
);

  apb_state_t  state;
  apb_state_t  state_nxt;
  logic        alive;
  logic [7:0]  wcnt;
  logic [7:0]  wcnt_inc;
  logic        tmo;
  logic        req_hs;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        write_q;
  logic [3:0]  strb_q;
  logic [2:0]  prot_q;

  // alive keeps req_ready low while reset is held
  assign req_ready = alive && (state == APB_IDLE);
  assign req_hs    = req_valid && req_ready;
  assign rsp_valid = (state == APB_RESP);

  assign out_psel    = (state == APB_SETUP) || (state == APB_ACCESS);
  assign out_penable = (state == APB_ACCESS);
  assign out_paddr   = addr_q;
  assign out_pwdata  = wdata_q;
  assign out_pwrite  = write_q;
  assign out_pstrb   = strb_q;
  assign out_pprot   = prot_q;

  assign wcnt_inc = (wcnt == 8'hFF) ? wcnt : wcnt + 8'd1;
  assign tmo = (TIMEOUT != 0) && (32'(wcnt_inc) == TIMEOUT);

  always_comb begin
    state_nxt = state;
    unique case (state)
      APB_IDLE:   if (req_hs) state_nxt = APB_SETUP;
      APB_SETUP:  state_nxt = APB_ACCESS;
      APB_ACCESS: if (out_pready || tmo) state_nxt = APB_RESP;
      APB_RESP:   if (rsp_ready) state_nxt = APB_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= APB_IDLE;
      alive <= 1'b0;
    end else begin
      state <= state_nxt;
      alive <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      strb_q  <= '0;
      prot_q  <= '0;
      wcnt    <= '0;
    end else if (req_hs) begin
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      write_q <= req_write;
      strb_q  <= req_write ? req_wstrb : 4'h0;
      prot_q  <= req_prot;
      wcnt    <= '0;
    end else if (state == APB_ACCESS && !out_pready) begin
      wcnt <= wcnt_inc;
    end
  end

  // pready wins over a timeout landing in the same cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (state == APB_ACCESS) begin
      if (out_pready) begin
        rsp_rdata <= write_q ? 32'h0 : out_prdata;
        rsp_err   <= out_pslverr;
      end else if (tmo) begin
        rsp_rdata <= 32'h0;
        rsp_err   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_initiator.sv
// Randomized self-checking bench for apb_initiator with a TIMEOUT of 16
// and a transaction-level expectation model.
module tb_apb_initiator;
  import apb_pkg::*;

  localparam int TMO = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        req_write = 1'b0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic [2:0]  req_prot = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] out_paddr;
  logic [31:0] out_pwdata;
  logic        out_psel;
  logic        out_penable;
  logic        out_pwrite;
  logic [2:0]  out_pprot;
  logic [3:0]  out_pstrb;
  logic        out_pready = 1'b0;
  logic        out_pslverr = 1'b0;
  logic [31:0] out_prdata = '0;

  int n_chk = 0;
  int n_fail = 0;

  apb_initiator #(.TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_write(req_write),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .req_prot(req_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .out_paddr(out_paddr), .out_pwdata(out_pwdata),
    .out_psel(out_psel), .out_penable(out_penable),
    .out_pwrite(out_pwrite), .out_pprot(out_pprot),
    .out_pstrb(out_pstrb), .out_pready(out_pready),
    .out_pslverr(out_pslverr), .out_prdata(out_prdata)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request at the current negedge; the slave inserts `waits`
  // wait states, then the response is held unconsumed for `hold` cycles.
  task automatic run_txn(input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s,
                         input logic [2:0] p, input int waits,
                         input logic serr, input logic [31:0] rd,
                         input int hold);
    int cyc;
    int acc;
    bit tmo;
    int lat;
    logic [3:0] es;
    logic [31:0] exp_rd;
    logic exp_err;
    tmo = (waits >= TMO);
    lat = tmo ? 2 + TMO : 3 + waits;
    es = wr ? s : 4'h0;
    exp_rd = (wr || tmo) ? 32'h0 : rd;
    exp_err = tmo ? 1'b1 : serr;
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr = a;
    req_wdata = d;
    req_wstrb = s;
    req_prot = p;
    cyc = 0;
    acc = 0;
    do begin
      @(negedge clock);
      cyc++;
      req_valid = 1'b0;
      req_addr = $urandom;
      req_wdata = $urandom;
      req_wstrb = 4'($urandom);
      req_prot = 3'($urandom);
      req_write = 1'($urandom);
      out_pready = 1'b0;
      out_pslverr = 1'($urandom);
      out_prdata = $urandom;
      if (out_psel) begin
        chk("paddr", out_paddr, a);
        chk("pwrite", 32'(out_pwrite), 32'(wr));
        chk("pwdata", out_pwdata, d);
        chk("pstrb", 32'(out_pstrb), 32'(es));
        chk("pprot", 32'(out_pprot), 32'(p));
        if (cyc == 1) chk("setup_penable", 32'(out_penable), 32'd0);
      end
      if (out_psel && out_penable) begin
        acc++;
        if (acc == waits + 1) begin
          out_pready = 1'b1;
          out_pslverr = serr;
          out_prdata = rd;
        end
      end
    end while (!rsp_valid && cyc < 60);
    out_pready = 1'b0;
    chk("latency", 32'(cyc), 32'(lat));
    chk("access_cycles", 32'(acc), 32'(tmo ? TMO : waits + 1));
    chk("resp_psel", 32'(out_psel), 32'd0);
    chk("resp_penable", 32'(out_penable), 32'd0);
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("rsp_err", 32'(rsp_err), 32'(exp_err));
    repeat (hold) begin
      @(negedge clock);
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rdata", rsp_rdata, exp_rd);
      chk("hold_err", 32'(rsp_err), 32'(exp_err));
      chk("hold_req_ready", 32'(req_ready), 32'd0);
      chk("hold_psel", 32'(out_psel), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
    chk("done_valid", 32'(rsp_valid), 32'd0);
    chk("done_req_ready", 32'(req_ready), 32'd1);
    chk("done_psel", 32'(out_psel), 32'd0);
  endtask

  initial begin
    @(negedge clock);
    @(negedge clock);
    chk("rst_psel", 32'(out_psel), 32'd0);
    chk("rst_penable", 32'(out_penable), 32'd0);
    chk("rst_paddr", out_paddr, 32'd0);
    chk("rst_pwdata", out_pwdata, 32'd0);
    chk("rst_pwrite", 32'(out_pwrite), 32'd0);
    chk("rst_pstrb", 32'(out_pstrb), 32'd0);
    chk("rst_pprot", 32'(out_pprot), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);

    run_txn(1'b1, 32'h1000_2000, 32'h0000_A5A5, 4'b0011,
            3'b000, 0, 1'b0, 32'hDEAD_BEEF, 0);
    run_txn(1'b0, 32'h1000_2004, 32'h5555_5555, 4'b1111,
            PPROT_PRIV, 3, 1'b0, 32'h0000_1234, 0);
    run_txn(1'b0, 32'h1000_2008, 32'h0, 4'b0000,
            PPROT_NSEC, 0, 1'b1, 32'h0BAD_0BAD, 0);
    run_txn(1'b0, 32'h1000_3000, 32'h0, 4'b0000,
            PPROT_INSTR, TMO, 1'b0, 32'h1111_2222, 0);
    run_txn(1'b1, 32'h1000_3004, 32'hCAFE_F00D, 4'b1100,
            3'b000, 1, 1'b0, 32'h0, 0);
    run_txn(1'b0, 32'h1000_3008, 32'h0, 4'b0000,
            3'b000, TMO - 1, 1'b0, 32'h7777_8888, 0);
    run_txn(1'b0, 32'h1000_300C, 32'h0, 4'b0000,
            3'b000, 2, 1'b1, 32'h9999_AAAA, 5);

    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr = 32'h1000_4000;
    req_wdata = 32'h1234_5678;
    req_wstrb = 4'hF;
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    chk("mid_penable", 32'(out_penable), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_psel", 32'(out_psel), 32'd0);
    chk("mid_rst_penable", 32'(out_penable), 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    chk("mid_rel_valid", 32'(rsp_valid), 32'd0);
    @(negedge clock);
    chk("mid_rel_req_ready", 32'(req_ready), 32'd1);
    repeat (3) begin
      @(negedge clock);
      chk("mid_no_rsp", 32'(rsp_valid), 32'd0);
      chk("mid_no_psel", 32'(out_psel), 32'd0);
    end

    for (int i = 0; i < 40; i++) begin
      run_txn(1'($urandom), $urandom, $urandom, 4'($urandom),
              3'($urandom), int'($urandom_range(0, 20)),
              1'($urandom), $urandom, int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
